// File: rtl/cdc_hs_tx.sv
// Source-side transmitter of a 4-phase req/ack bus synchronizer.
// Holds a captured word on TX_DATA while TX_REQ is up and retires it on the synchronized ack.
module cdc_hs_tx #(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] DATA_IN,
    input  logic                 DATA_VALID,
    output logic                 READY,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 TX_REQ,
    input  logic                 ACK_ASYNC,
    output logic                 DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_STAGES-1:0]  ack_sync_q;
    logic                   ack_sync;
    logic [BUS_WIDTH-1:0]   tx_data_d;
    logic                   tx_req_d;
    logic                   done_d;

    // Acknowledge resynchronizer; only the last stage is ever consumed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ACK_ASYNC};
        end
    end

    assign ack_sync = ack_sync_q[NUM_STAGES-1];

    // A stale ack from the previous transfer blocks a new request.
    assign READY = (state_q == ST_IDLE) && !ack_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            TX_DATA <= '0;
            TX_REQ  <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_DATA <= tx_data_d;
            TX_REQ  <= tx_req_d;
            DONE    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = TX_DATA;
        tx_req_d  = TX_REQ;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DATA_VALID && READY) begin
                    tx_data_d = DATA_IN;
                    tx_req_d  = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_sync) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed plus randomized bench for cdc_hs_tx; the bench plays the destination domain.
// Expected timing is derived from the handshake rules: ack visible after NS edges, acted on at the next.
module tb_cdc_hs_tx;

    localparam int unsigned BW = 8;
    localparam int unsigned NS = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic [BW-1:0] DATA_IN;
    logic          DATA_VALID;
    logic          READY;
    logic [BW-1:0] TX_DATA;
    logic          TX_REQ;
    logic          ACK_ASYNC;
    logic          DONE;

    int n_cmp = 0;
    int n_err = 0;

    int       acc;
    int       dones;
    int       done_cyc;
    logic     prev_req;
    logic [7:0] w;

    cdc_hs_tx #(.BUS_WIDTH(BW), .NUM_STAGES(NS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .READY      (READY),
        .TX_DATA    (TX_DATA),
        .TX_REQ     (TX_REQ),
        .ACK_ASYNC  (ACK_ASYNC),
        .DONE       (DONE)
    );

    always #10 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word for a single edge and confirm it was captured.
    task automatic accept(input logic [7:0] wd);
        chk("ready_before_accept", 32'(READY), 32'd1);
        DATA_VALID = 1'b1;
        DATA_IN    = wd;
        step();
        DATA_VALID = 1'b0;
        chk("req_after_accept", 32'(TX_REQ), 32'd1);
        chk("data_after_accept", 32'(TX_DATA), 32'(wd));
        chk("ready_busy", 32'(READY), 32'd0);
    endtask

    // Destination side: wait d1, raise ack, wait d2 after req drops, release ack.
    task automatic finish(input logic [7:0] wd, input int d1, input int d2,
                          input bit noise, input logic [7:0] nword);
        for (int i = 0; i < d1; i++) begin
            if (noise) begin
                DATA_VALID = 1'b1;
                DATA_IN    = nword;
            end
            step();
            chk("req_wait_ack", 32'(TX_REQ), 32'd1);
            chk("data_hold_req", 32'(TX_DATA), 32'(wd));
            chk("ready_in_req", 32'(READY), 32'd0);
        end
        DATA_VALID = 1'b0;
        ACK_ASYNC  = 1'b1;
        for (int i = 0; i < int'(NS); i++) begin
            step();
            chk("req_held_during_sync", 32'(TX_REQ), 32'd1);
        end
        step();
        chk("req_drop", 32'(TX_REQ), 32'd0);
        chk("no_done_on_req_drop", 32'(DONE), 32'd0);
        chk("data_hold_release", 32'(TX_DATA), 32'(wd));
        for (int i = 0; i < d2; i++) begin
            if (noise) begin
                DATA_VALID = 1'b1;
                DATA_IN    = 8'($urandom);
            end
            step();
            chk("req_low_release", 32'(TX_REQ), 32'd0);
            chk("ready_in_release", 32'(READY), 32'd0);
            chk("done_early", 32'(DONE), 32'd0);
        end
        DATA_VALID = 1'b0;
        ACK_ASYNC  = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            step();
            chk("done_before_sync", 32'(DONE), 32'd0);
            chk("ready_before_sync", 32'(READY), 32'd0);
        end
        step();
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("ready_on_done", 32'(READY), 32'd1);
        chk("data_on_done", 32'(TX_DATA), 32'(wd));
        chk("req_on_done", 32'(TX_REQ), 32'd0);
        step();
        chk("done_one_cycle", 32'(DONE), 32'd0);
        chk("req_idle", 32'(TX_REQ), 32'd0);
        chk("data_retained", 32'(TX_DATA), 32'(wd));
    endtask

    initial begin
        RST        = 1'b1;
        DATA_VALID = 1'b1;
        DATA_IN    = 8'hFF;
        ACK_ASYNC  = 1'b0;

        // Reset values while valid is driven
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req", 32'(TX_REQ), 32'd0);
        chk("rst_data", 32'(TX_DATA), 32'h00);
        chk("rst_done", 32'(DONE), 32'd0);
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        step();
        chk("ready_after_rst", 32'(READY), 32'd1);
        chk("req_after_rst", 32'(TX_REQ), 32'd0);

        // Single transfer with busy-ignore noise during REQ
        accept(8'hA5);
        finish(8'hA5, 3, 1, 1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_second_req", 32'(TX_REQ), 32'd0);
            chk("busy_word_dropped", 32'(TX_DATA), 32'hA5);
        end

        // Back-to-back with the destination echoing req as ack
        acc        = 0;
        dones      = 0;
        done_cyc   = -10;
        prev_req   = 1'b0;
        DATA_VALID = 1'b1;
        DATA_IN    = 8'h11;
        for (int c = 0; c < 40; c++) begin
            step();
            if (TX_REQ && !prev_req) begin
                acc++;
                if (acc == 1) begin
                    chk("b2b_first_word", 32'(TX_DATA), 32'h11);
                    DATA_IN = 8'h22;
                end else begin
                    chk("b2b_second_word", 32'(TX_DATA), 32'h22);
                    chk("b2b_accept_on_done", 32'(c), 32'(done_cyc + 1));
                    DATA_VALID = 1'b0;
                end
            end
            if (DONE) begin
                dones++;
                done_cyc = c;
            end
            prev_req  = TX_REQ;
            ACK_ASYNC = TX_REQ;
        end
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_dones", 32'(dones), 32'd2);
        ACK_ASYNC  = 1'b0;
        DATA_VALID = 1'b0;
        repeat (NS + 1) step();

        // Reset in the middle of a request
        accept(8'h5A);
        step();
        step();
        RST = 1'b1;
        #1;
        chk("midrst_req", 32'(TX_REQ), 32'd0);
        chk("midrst_data", 32'(TX_DATA), 32'h00);
        chk("midrst_done", 32'(DONE), 32'd0);
        step();
        RST = 1'b0;
        step();
        chk("midrst_no_done", 32'(DONE), 32'd0);
        chk("midrst_ready", 32'(READY), 32'd1);
        accept(8'h0F);
        finish(8'h0F, 1, 1, 1'b0, 8'h00);

        // Stuck acknowledge while idle
        ACK_ASYNC = 1'b1;
        step();
        chk("stuck_ready_first_edge", 32'(READY), 32'd1);
        step();
        chk("stuck_ready_low", 32'(READY), 32'd0);
        DATA_VALID = 1'b1;
        DATA_IN    = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stuck_no_req", 32'(TX_REQ), 32'd0);
            chk("stuck_no_done", 32'(DONE), 32'd0);
            chk("stuck_ready", 32'(READY), 32'd0);
        end
        ACK_ASYNC = 1'b0;
        step();
        chk("stuck_ready_still_low", 32'(READY), 32'd0);
        step();
        chk("stuck_ready_back", 32'(READY), 32'd1);
        chk("stuck_req_not_yet", 32'(TX_REQ), 32'd0);
        step();
        DATA_VALID = 1'b0;
        chk("stuck_pending_req", 32'(TX_REQ), 32'd1);
        chk("stuck_pending_data", 32'(TX_DATA), 32'h77);
        finish(8'h77, 0, 0, 1'b0, 8'h00);

        // Randomized transfers with random destination latency and busy noise
        for (int k = 0; k < 8; k++) begin
            w = 8'($urandom);
            accept(w);
            finish(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
